// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared constants and types for the ADXL362-style SPI target
package spi_target_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;

  localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
  localparam logic [7:0] ADDR_PARTID    = 8'h02;
  localparam logic [7:0] ADDR_XDATA_L   = 8'h0E;
  localparam logic [7:0] ADDR_ZDATA_H   = 8'h13;
  localparam logic [7:0] ADDR_RO_LIMIT  = 8'h14;

  localparam logic [7:0] RST_DEVID_AD   = 8'hAD;
  localparam logic [7:0] RST_DEVID_MST  = 8'h1D;
  localparam logic [7:0] RST_PARTID     = 8'hF2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } spi_state_t;

  function automatic logic [7:0] reg_reset_value(input logic [7:0] addr);
    case (addr)
      ADDR_DEVID_AD:  return RST_DEVID_AD;
      ADDR_DEVID_MST: return RST_DEVID_MST;
      ADDR_PARTID:    return RST_PARTID;
      default:        return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with registered rise/fall pulse outputs
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{INIT}};
      prev  <= INIT;
    end else begin
      chain <= (chain << 1) | STAGES'(din);
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_accel_target.sv
// rtl/spi_accel_target.sv - SPI mode-0 target with auto-incrementing byte register bank and XYZ load port
module spi_accel_target
  import spi_target_pkg::*;
#(
  parameter int NUM_REGS    = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs,
  input  logic        copi,
  output logic        cipo,
  output logic        cipo_oe,
  input  logic        data_load,
  input  logic [47:0] data_in,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data
);

  localparam int AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int XYZ_BYTES = int'(ADDR_ZDATA_H) - int'(ADDR_XDATA_L) + 1;

  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic                   copi_q, cs_low, cs_active, byte_done;
  logic                   is_read, tx_hold, load_pending;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             rx_byte, tx_shift, ptr, ptr_next;
  logic [47:0]            load_data;
  logic [7:0]             bank [NUM_REGS];
  spi_state_t             state, state_next;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
    .clock(clock), .reset(reset), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
    .clock(clock), .reset(reset), .din(cs), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) copi_sync <= '0;
    else       copi_sync <= (copi_sync << 1) | SYNC_STAGES'(copi);
  end

  function automatic logic in_range(input logic [7:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  function automatic logic [7:0] bank_rd(input logic [7:0] a);
    return in_range(a) ? bank[a[AW-1:0]] : 8'h00;
  endfunction

  assign copi_q    = copi_sync[SYNC_STAGES-1];
  // a cs rise wins over any sclk edge seen in the same cycle
  assign cs_active = cs_low & ~cs_rise;
  assign rx_byte   = {rx_shift, copi_q};
  assign byte_done = cs_active & sclk_rise & (bit_cnt == 3'd7);
  assign ptr_next  = (int'(ptr) == NUM_REGS - 1) ? 8'h00 : ptr + 8'h01;
  assign cipo_oe   = cs_low;
  assign cipo      = cs_low & tx_shift[7];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else if (cs_fall) begin
      state_next = ST_CMD;
    end else if (byte_done) begin
      case (state)
        ST_CMD:  state_next = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: state_next = ST_DATA;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_low       <= 1'b0;
      bit_cnt      <= 3'd0;
      rx_shift     <= 7'd0;
      tx_shift     <= 8'h00;
      tx_hold      <= 1'b0;
      is_read      <= 1'b0;
      ptr          <= 8'h00;
      wr_valid     <= 1'b0;
      wr_addr      <= 8'h00;
      wr_data      <= 8'h00;
      load_pending <= 1'b0;
      load_data    <= 48'h0;
      for (int i = 0; i < NUM_REGS; i++) bank[AW'(i)] <= reg_reset_value(8'(i));
    end else begin
      wr_valid <= 1'b0;
      if (cs_fall)      cs_low <= 1'b1;
      else if (cs_rise) cs_low <= 1'b0;

      if (cs_fall) begin
        bit_cnt  <= 3'd0;
        tx_shift <= 8'h00;
        tx_hold  <= 1'b0;
      end else if (cs_active) begin
        if (sclk_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            ST_CMD: is_read <= (rx_byte == CMD_READ);
            ST_ADDR: begin
              ptr <= rx_byte;
              if (is_read) begin
                tx_shift <= bank_rd(rx_byte);
                tx_hold  <= 1'b1;
              end
            end
            ST_DATA: begin
              if (is_read) begin
                tx_shift <= bank_rd(ptr_next);
                tx_hold  <= 1'b1;
              end else if (ptr >= ADDR_RO_LIMIT && in_range(ptr)) begin
                bank[ptr[AW-1:0]] <= rx_byte;
                wr_valid          <= 1'b1;
                wr_addr           <= ptr;
                wr_data           <= rx_byte;
              end
              ptr <= ptr_next;
            end
            default: ;
          endcase
        end
        // the bit just loaded must survive the fall that follows its load
        if (sclk_fall) begin
          if (tx_hold) tx_hold  <= 1'b0;
          else         tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end

      // XYZ samples are deferred while a frame is open so a burst never tears a sample
      if (load_pending && !cs_low) begin
        for (int i = 0; i < XYZ_BYTES; i++) bank[AW'(int'(ADDR_XDATA_L) + i)] <= load_data[8*i +: 8];
        load_pending <= 1'b0;
      end
      if (data_load) begin
        if (cs_low) begin
          load_data    <= data_in;
          load_pending <= 1'b1;
        end else begin
          for (int i = 0; i < XYZ_BYTES; i++) bank[AW'(int'(ADDR_XDATA_L) + i)] <= data_in[8*i +: 8];
          load_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_accel_target.sv
// tb/tb_spi_accel_target.sv - scoreboard bench for spi_accel_target
module tb_spi_accel_target;

  localparam int H = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        copi = 1'b0;
  logic        data_load = 1'b0;
  logic [47:0] data_in = 48'h0;
  logic        cipo, cipo_oe, wr_valid;
  logic [7:0]  wr_addr, wr_data;

  int          checks = 0;
  int          passes = 0;
  logic [7:0]  rd_exp[$];
  logic [15:0] wr_exp[$];
  logic [7:0]  mon_sh = 8'h00;
  int          mon_cnt = 0;

  spi_accel_target dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs(cs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .data_load(data_load), .data_in(data_in),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // cipo monitor: one comparison per completed 8-bit SPI byte
  always @(posedge sclk or posedge cs) begin
    if (cs) begin
      mon_cnt = 0;
    end else begin
      mon_sh = {mon_sh[6:0], cipo};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (rd_exp.size() == 0) begin
          checks++;
          $display("FAIL cipo_byte: got %0h expected none", mon_sh);
        end else begin
          chk("cipo_byte", 48'(mon_sh), 48'(rd_exp.pop_front()));
        end
      end
    end
  end

  // write-report monitor
  always @(negedge clock) begin
    if (wr_valid === 1'b1) begin
      if (wr_exp.size() == 0) begin
        checks++;
        $display("FAIL wr_pulse: got %0h/%0h expected none", wr_addr, wr_data);
      end else begin
        chk("wr_pulse", 48'({wr_addr, wr_data}), 48'(wr_exp.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic begin_frame;
    cs = 1'b0;
    idle(H);
    chk("cipo_oe_in_frame", 48'(cipo_oe), 48'd1);
  endtask

  task automatic end_frame;
    idle(H);
    cs   = 1'b1;
    copi = 1'b0;
    idle(2 * H);
    chk("cipo_oe_idle", 48'(cipo_oe), 48'd0);
  endtask

  task automatic sbit(input logic b);
    copi = b;
    idle(H);
    sclk = 1'b1;
    idle(H);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
    rd_exp.push_back(exp);
    for (int i = 7; i >= 0; i--) sbit(tx[i]);
  endtask

  task automatic pulse_load(input logic [47:0] v);
    data_in   = v;
    data_load = 1'b1;
    idle(1);
    data_load = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("rst_cipo", 48'(cipo), 48'd0);
    chk("rst_cipo_oe", 48'(cipo_oe), 48'd0);
    chk("rst_wr_valid", 48'(wr_valid), 48'd0);
    chk("rst_wr_addr", 48'(wr_addr), 48'd0);
    chk("rst_wr_data", 48'(wr_data), 48'd0);
    reset = 1'b0;
    idle(4);

    // device ID
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h00, 8'h00);
    xfer(8'h00, 8'hAD); xfer(8'h00, 8'h1D); xfer(8'h00, 8'hF2); end_frame;

    // write burst with auto-increment, then read back
    begin_frame; xfer(8'h0A, 8'h00); xfer(8'h2D, 8'h00);
    wr_exp.push_back(16'h2D02); xfer(8'h02, 8'h00);
    wr_exp.push_back(16'h2E05); xfer(8'h05, 8'h00); end_frame;
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h2D, 8'h00);
    xfer(8'h00, 8'h02); xfer(8'h00, 8'h05); end_frame;

    // read-only window, unknown command, lowest writable address, wrap into RO space
    begin_frame; xfer(8'h0A, 8'h00); xfer(8'h10, 8'h00); xfer(8'h55, 8'h00); end_frame;
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h10, 8'h00); xfer(8'h00, 8'h00); end_frame;
    begin_frame; xfer(8'h0C, 8'h00); xfer(8'h00, 8'h00); xfer(8'hFF, 8'h00); xfer(8'hFF, 8'h00); end_frame;
    begin_frame; xfer(8'h0A, 8'h00); xfer(8'h14, 8'h00);
    wr_exp.push_back(16'h1499); xfer(8'h99, 8'h00); end_frame;
    begin_frame; xfer(8'h0A, 8'h00); xfer(8'h3F, 8'h00);
    wr_exp.push_back(16'h3F3C); xfer(8'h3C, 8'h00); xfer(8'h11, 8'h00); end_frame;
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h50, 8'h00); xfer(8'h00, 8'h00); xfer(8'h00, 8'h00); end_frame;

    // sample loads: immediate with cs high, deferred during a burst
    pulse_load(48'h665544332211);
    idle(2);
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h0E, 8'h00); xfer(8'h00, 8'h11);
    pulse_load(48'h060504030201);
    xfer(8'h00, 8'h22); xfer(8'h00, 8'h33); xfer(8'h00, 8'h44);
    xfer(8'h00, 8'h55); xfer(8'h00, 8'h66); end_frame;
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h0E, 8'h00);
    xfer(8'h00, 8'h01); xfer(8'h00, 8'h02); xfer(8'h00, 8'h03);
    xfer(8'h00, 8'h04); xfer(8'h00, 8'h05); xfer(8'h00, 8'h06); end_frame;

    // read wrap from the top address, then an aborted partial write byte
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h3F, 8'h00); xfer(8'h00, 8'h3C); xfer(8'h00, 8'hAD); end_frame;
    begin_frame; xfer(8'h0A, 8'h00); xfer(8'h30, 8'h00);
    for (int i = 7; i >= 3; i--) sbit(1'b1);
    end_frame;
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h30, 8'h00); xfer(8'h00, 8'h00); end_frame;

    // reset in the middle of a read data byte
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h00, 8'h00);
    sbit(1'b0); sbit(1'b0);
    idle(H);
    chk("cipo_before_reset", 48'(cipo), 48'd1);
    reset = 1'b1;
    #1;
    chk("cipo_in_reset", 48'(cipo), 48'd0);
    chk("cipo_oe_in_reset", 48'(cipo_oe), 48'd0);
    idle(2);
    cs = 1'b1;
    idle(2 * H);
    reset = 1'b0;
    idle(4);
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h00, 8'h00);
    xfer(8'h00, 8'hAD); xfer(8'h00, 8'h1D); xfer(8'h00, 8'hF2); end_frame;
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h2D, 8'h00); xfer(8'h00, 8'h00); end_frame;
    begin_frame; xfer(8'h0B, 8'h00); xfer(8'h0E, 8'h00); xfer(8'h00, 8'h00); end_frame;

    idle(20);
    chk("rd_queue_drained", 48'(rd_exp.size()), 48'd0);
    chk("wr_queue_drained", 48'(wr_exp.size()), 48'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
